// File: rtl/div_if.sv
// Handshake/result bundle for div_unit: the master drives the i_* request fields,
// the slave (div_unit) drives the o_* results plus a debug view of its FSM state.
interface div_if #(
  parameter int WIDTH = 32
);
  // Handshake: a request is accepted on any rising edge where i_start is high and
  // o_busy is low (unit in IDLE or DONE); i_signed/i_dividend/i_divisor must be valid
  // in that same cycle. A request made while o_busy is high is dropped, not queued.
  // o_done pulses for one cycle when o_quotient/o_remainder/o_div_zero become valid.
  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_zero;
  logic [1:0]       dbg_state;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder, o_div_zero, dbg_state
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder, o_div_zero, dbg_state
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (signed DIV / unsigned DIVU), one quotient bit per cycle.
// Optional macro DIV_ZERO_SHORTCUT_EN: divide-by-zero skips iteration and finishes at once.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  resetn,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr, quo, rem, dvnd_orig;
  logic [WIDTH-1:0] q_out, r_out;
  logic             neg_q, neg_r, dz, dz_out;

  logic             accept, zero_div, last_step;
  logic [WIDTH-1:0] dvnd_abs, dvsr_abs;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    accept    = bus.i_start && ((state == IDLE) || (state == DONE));
    zero_div  = (bus.i_divisor == '0);
    dvnd_abs  = (bus.i_signed && bus.i_dividend[WIDTH-1]) ? -bus.i_dividend : bus.i_dividend;
    dvsr_abs  = (bus.i_signed && bus.i_divisor[WIDTH-1])  ? -bus.i_divisor  : bus.i_divisor;
    // Extra bit keeps the carry when the partial remainder has its MSB set;
    // diff[WIDTH] is the borrow because the remainder is always below the divisor.
    shifted   = {rem, quo[WIDTH-1]};
    diff      = shifted - {1'b0, dvsr};
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          state_nxt = zero_div ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last_step) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      dvsr      <= '0;
      quo       <= '0;
      rem       <= '0;
      dvnd_orig <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      q_out     <= '0;
      r_out     <= '0;
      dz_out    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt       <= '0;
            dvsr      <= dvsr_abs;
            quo       <= dvnd_abs;
            rem       <= '0;
            dvnd_orig <= bus.i_dividend;
            neg_q     <= bus.i_signed && (bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1]);
            neg_r     <= bus.i_signed && bus.i_dividend[WIDTH-1];
            dz        <= zero_div;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (zero_div) begin
              q_out  <= '1;
              r_out  <= bus.i_dividend;
              dz_out <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
        SIGN: begin
          // Divide-by-zero results ignore the sign fixup entirely.
          if (dz) begin
            q_out <= '1;
            r_out <= dvnd_orig;
          end else begin
            q_out <= neg_q ? -quo : quo;
            r_out <= neg_r ? -rem : rem;
          end
          dz_out <= dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = (state == RUN) || (state == SIGN);
  assign bus.o_done      = (state == DONE);
  assign bus.o_quotient  = q_out;
  assign bus.o_remainder = r_out;
  assign bus.o_div_zero  = dz_out;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, busy window, signed/unsigned results,
// overflow, divide-by-zero (either build), ignored start, back-to-back and mid-run reset.
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int DZ_LAT  = 1;
  localparam int DZ_BUSY = 0;
`else
  localparam int DZ_LAT  = 34;
  localparam int DZ_BUSY = 33;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  div_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_signed   = s;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Counts samples (1 = right after the start edge) until o_done, and busy samples on the way.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = bus.o_busy ? 1 : 0;
    while (!bus.o_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.o_busy) busy_cnt++;
    end
    if (!bus.o_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: o_done not seen after %0d cycles", lat);
    end
  endtask

  task automatic test_reset;
    resetn         = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_signed   = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dz got %b%b%b expected 000", bus.o_busy, bus.o_done, bus.o_div_zero);
    end
    checks++;
    if ({bus.o_quotient, bus.o_remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_results: got q=%h r=%h expected 0", bus.o_quotient, bus.o_remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat, bc;
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL udiv_latency: got %0d expected 34", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL udiv_busy_cycles: got %0d expected 33", bc); end
    checks++;
    if ({bus.o_quotient, bus.o_remainder, bus.o_div_zero} !== {32'd14, 32'd2, 1'b0}) begin
      errors++;
      $display("FAIL udiv_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0", bus.o_quotient, bus.o_remainder, bus.o_div_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: o_done got %b expected 0", bus.o_done); end
    checks++;
    if (bus.o_quotient !== 32'd14) begin errors++; $display("FAIL result_hold: q got %0d expected 14", bus.o_quotient); end
  endtask

  task automatic test_signed;
    // {signed, dividend, divisor, quotient, remainder}
    logic [128:0] vec [6];
    int lat, bc;
    vec[0] = {1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vec[1] = {1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0};
    vec[2] = {1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vec[3] = {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
    vec[4] = {1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF};
    vec[5] = {1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      launch(vec[i][128], vec[i][127:96], vec[i][95:64]);
      wait_done(lat, bc);
      checks++;
      if ({bus.o_quotient, bus.o_remainder, bus.o_div_zero} !== {vec[i][63:0], 1'b0}) begin
        errors++;
        $display("FAIL div_vec%0d: got q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                 i, bus.o_quotient, bus.o_remainder, bus.o_div_zero, vec[i][63:32], vec[i][31:0]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] dv [3];
    logic         sg [3];
    int lat, bc;
    dv[0] = 32'h1234_5678; sg[0] = 1'b0;
    dv[1] = 32'h1234_5678; sg[1] = 1'b1;
    dv[2] = 32'h8765_4321; sg[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      launch(sg[i], dv[i], 32'd0);
      wait_done(lat, bc);
      checks++;
      if (lat !== DZ_LAT || bc !== DZ_BUSY) begin
        errors++;
        $display("FAIL dz%0d_timing: got lat=%0d busy=%0d expected lat=%0d busy=%0d", i, lat, bc, DZ_LAT, DZ_BUSY);
      end
      checks++;
      if ({bus.o_quotient, bus.o_remainder, bus.o_div_zero} !== {32'hFFFF_FFFF, dv[i], 1'b1}) begin
        errors++;
        $display("FAIL dz%0d_result: got q=%h r=%h dz=%b expected q=ffffffff r=%h dz=1",
                 i, bus.o_quotient, bus.o_remainder, bus.o_div_zero, dv[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    bus.i_start    = 1'b1;
    bus.i_dividend = 32'd9;
    bus.i_divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 24) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 24", lat); end
    checks++;
    if ({bus.o_quotient, bus.o_remainder} !== {32'd10, 32'd0}) begin
      errors++;
      $display("FAIL ignored_start_result: got q=%0d r=%0d expected q=10 r=0", bus.o_quotient, bus.o_remainder);
    end
    // Start again while still in DONE.
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_quotient} !== {1'b1, 32'd10}) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b q=%0d expected busy=1 q=10", bus.o_busy, bus.o_quotient);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    checks++;
    if ({bus.o_quotient, bus.o_remainder} !== {32'd3, 32'd0}) begin
      errors++;
      $display("FAIL b2b_result: got q=%0d r=%0d expected q=3 r=0", bus.o_quotient, bus.o_remainder);
    end
  endtask

  task automatic test_reset_midrun;
    int lat, bc, done_seen;
    launch(1'b0, 32'd100, 32'd7);
    repeat (19) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_quotient, bus.o_remainder} !== 67'd0) begin
      errors++;
      $display("FAIL midrun_reset_clear: got busy=%b done=%b dz=%b q=%h r=%h expected all 0",
               bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_quotient, bus.o_remainder);
    end
    resetn    = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.o_done || bus.o_busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL midrun_abort: busy/done seen %0d cycles expected 0", done_seen); end
    launch(1'b0, 32'd9, 32'd3);
    wait_done(lat, bc);
    checks++;
    if ({bus.o_quotient, bus.o_remainder, lat} !== {32'd3, 32'd0, 32'd34}) begin
      errors++;
      $display("FAIL post_reset_div: got q=%0d r=%0d lat=%0d expected q=3 r=0 lat=34", bus.o_quotient, bus.o_remainder, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_back_to_back;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
